// File: rtl/conv3x3_stream_ctrl_pkg.sv
// Shared definitions for the 3x3 convolution frame sequencer: FSM encoding
// and frame geometry helpers.
package conv3x3_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } conv_state_e;

    localparam int CNT_WIDTH = 32;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/conv3x3_stream_ctrl_skid.sv
// One-deep skid buffer that catches a memory read return arriving while the
// downstream stage is stalled, and replays it first once the stall clears.
module conv_skid_reg #(
    parameter int DATA_WIDHT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDHT-1:0] in_data,
    input  logic                  stall,
    output logic                  out_valid,
    output logic [DATA_WIDHT-1:0] out_data,
    output logic                  full
);

    logic                  full_reg;
    logic [DATA_WIDHT-1:0] data_reg;

    assign full      = full_reg;
    assign out_valid = !stall && (full_reg || in_valid);

    // Held data always goes out before any fresh return; idle data reads as zero.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = full_reg ? data_reg : in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (stall) begin
            if (!full_reg && in_valid) begin
                full_reg <= 1'b1;
                data_reg <= in_data;
            end
        end else if (full_reg) begin
            full_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/conv3x3_stream_ctrl.sv
// Frame sequencer: clears the window generator, streams one raster frame from a
// 1-cycle-latency pixel memory, appends zero flush beats and counts windows.
module conv3x3_stream_ctrl
    import conv3x3_stream_ctrl_pkg::*;
#(
    parameter int IMG_WIDHT  = 299,
    parameter int IMG_HEIGHT = 299,
    parameter int DATA_WIDHT = 32,
    parameter int ADDR_WIDHT = 17,
    parameter int FLUSH_LEN  = IMG_WIDHT + 2,
    parameter int CLR_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Stall_In,
    output logic                  Mem_Rd_En,
    output logic [ADDR_WIDHT-1:0] Mem_Addr,
    input  logic [DATA_WIDHT-1:0] Mem_Data,
    output logic                  Win_Rst_n,
    output logic                  Win_Valid_In,
    output logic [DATA_WIDHT-1:0] Win_Data_In,
    input  logic                  Win_Valid_Out,
    output logic [31:0]           Window_Count,
    output logic                  Busy,
    output logic                  Done
);

    localparam int                    FRAME      = frame_pixels(IMG_WIDHT, IMG_HEIGHT);
    localparam logic [ADDR_WIDHT-1:0] LAST_ADDR  = ADDR_WIDHT'(FRAME - 1);
    localparam logic [CNT_WIDTH-1:0]  FRAME_CNT  = CNT_WIDTH'(FRAME);
    localparam logic [CNT_WIDTH-1:0]  PIX_LAST   = CNT_WIDTH'(FRAME - 1);
    localparam logic [CNT_WIDTH-1:0]  FLUSH_LAST = CNT_WIDTH'(FLUSH_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  CLR_LAST   = CNT_WIDTH'(CLR_CYCLES - 1);

    conv_state_e state_reg, state_next;

    logic [ADDR_WIDHT-1:0] addr_reg;
    logic                  rd_done_reg;
    logic                  rd_pend_reg;
    logic [CNT_WIDTH-1:0]  pix_cnt_reg;
    logic [CNT_WIDTH-1:0]  flush_cnt_reg;
    logic [CNT_WIDTH-1:0]  clr_cnt_reg;
    logic [CNT_WIDTH-1:0]  win_cnt_reg;

    logic                  rd_en;
    logic                  skid_valid;
    logic [DATA_WIDHT-1:0] skid_data;
    logic                  skid_full;
    logic                  feed_beat;
    logic                  flush_beat;
    logic                  count_en;
    logic                  start_accept;

    // A new read is only launched when its return is guaranteed a home:
    // either delivered directly or caught by an empty skid register.
    assign rd_en = (state_reg == ST_FEED) && !rd_done_reg && !Stall_In && !skid_full;

    conv_skid_reg #(
        .DATA_WIDHT(DATA_WIDHT)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rd_pend_reg),
        .in_data  (Mem_Data),
        .stall    (Stall_In),
        .out_valid(skid_valid),
        .out_data (skid_data),
        .full     (skid_full)
    );

    assign feed_beat    = (state_reg == ST_FEED) && skid_valid;
    assign flush_beat   = (state_reg == ST_FLUSH) && !Stall_In;
    assign start_accept = (state_reg == ST_IDLE) && Start;
    assign count_en     = (feed_beat || flush_beat) && Win_Valid_Out && (win_cnt_reg != FRAME_CNT);

    assign Mem_Rd_En    = rd_en;
    assign Mem_Addr     = addr_reg;
    assign Win_Valid_In = feed_beat || flush_beat;
    assign Win_Data_In  = feed_beat ? skid_data : '0;
    assign Window_Count = win_cnt_reg;
    assign Busy         = (state_reg != ST_IDLE);
    assign Done         = (state_reg == ST_DONE);
    assign Win_Rst_n    = (state_reg != ST_CLEAR);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (Start) state_next = ST_CLEAR;
            ST_CLEAR: if (clr_cnt_reg == CLR_LAST) state_next = ST_FEED;
            ST_FEED:  if (feed_beat && (pix_cnt_reg == PIX_LAST)) state_next = ST_FLUSH;
            ST_FLUSH: if (flush_beat && (flush_cnt_reg == FLUSH_LAST)) state_next = ST_DRAIN;
            ST_DRAIN: if (win_cnt_reg == FRAME_CNT) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            rd_done_reg   <= 1'b0;
            rd_pend_reg   <= 1'b0;
            pix_cnt_reg   <= '0;
            flush_cnt_reg <= '0;
            clr_cnt_reg   <= '0;
            win_cnt_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            rd_pend_reg <= rd_en;

            if (start_accept) begin
                addr_reg      <= '0;
                rd_done_reg   <= 1'b0;
                pix_cnt_reg   <= '0;
                flush_cnt_reg <= '0;
                clr_cnt_reg   <= '0;
                win_cnt_reg   <= '0;
            end

            if (state_reg == ST_CLEAR) begin
                clr_cnt_reg <= clr_cnt_reg + 1'b1;
            end

            // Address parks on the last pixel instead of running past the frame.
            if (rd_en) begin
                if (addr_reg == LAST_ADDR) begin
                    rd_done_reg <= 1'b1;
                end else begin
                    addr_reg <= addr_reg + 1'b1;
                end
            end

            if (feed_beat) begin
                pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end

            if (flush_beat) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end

            if (count_en) begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Scoreboard bench for conv3x3_stream_ctrl on a 4x4 frame with a behavioural
// pixel memory and a simple window-generator model.
module tb_conv3x3_stream_ctrl;

    localparam int W      = 4;
    localparam int H      = 4;
    localparam int N      = W * H;
    localparam int FL     = W + 2;
    localparam int DW     = 32;
    localparam int AW     = 17;
    localparam int MAXCYC = 600;

    logic          clk;
    logic          rst;
    logic          Start;
    logic          Stall_In;
    logic          Mem_Rd_En;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_Data;
    logic          Win_Rst_n;
    logic          Win_Valid_In;
    logic [DW-1:0] Win_Data_In;
    logic          Win_Valid_Out;
    logic [31:0]   Window_Count;
    logic          Busy;
    logic          Done;

    conv3x3_stream_ctrl #(
        .IMG_WIDHT (W),
        .IMG_HEIGHT(H),
        .DATA_WIDHT(DW),
        .ADDR_WIDHT(AW),
        .FLUSH_LEN (FL),
        .CLR_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Start        (Start),
        .Stall_In     (Stall_In),
        .Mem_Rd_En    (Mem_Rd_En),
        .Mem_Addr     (Mem_Addr),
        .Mem_Data     (Mem_Data),
        .Win_Rst_n    (Win_Rst_n),
        .Win_Valid_In (Win_Valid_In),
        .Win_Data_In  (Win_Data_In),
        .Win_Valid_Out(Win_Valid_Out),
        .Window_Count (Window_Count),
        .Busy         (Busy),
        .Done         (Done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel memory with one cycle of read latency.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] mem_q;
    always @(posedge clk) begin
        if (Mem_Rd_En) mem_q <= mem[Mem_Addr[3:0]];
    end
    assign Mem_Data = mem_q;

    // Window generator model: after FL warm-up beats every beat yields a window.
    logic force_vo = 1'b0;
    int   beat_cnt;
    int   exp_win;
    assign Win_Valid_Out = force_vo || (Win_Valid_In && (beat_cnt >= FL));

    always @(posedge clk) begin
        if (rst || (Start && !Busy)) begin
            beat_cnt <= 0;
            exp_win  <= 0;
        end else begin
            if (Win_Valid_In) beat_cnt <= beat_cnt + 1;
            if (Win_Valid_In && Win_Valid_Out && (exp_win < N)) exp_win <= exp_win + 1;
        end
    end

    logic [DW-1:0] exp_q[$];
    int  beats_seen, rd_cnt, done_cnt, clr_low, first_lat, lat_cnt, exp_rd_addr;
    bit  lat_armed;
    int  stall_mode = 0;
    bit  hold_done  = 1'b0;

    // Monitor: pops the scoreboard on each beat and checks protocol rules.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (Start && !Busy) begin
                beats_seen  = 0;
                rd_cnt      = 0;
                done_cnt    = 0;
                clr_low     = 0;
                first_lat   = -1;
                exp_rd_addr = 0;
                lat_armed   = 1'b0;
            end
            if (!rst) begin
                if (Win_Valid_In) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", 64'(Win_Data_In), 64'hDEAD_BEEF_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'(Win_Data_In), 64'(e));
                    end
                end else begin
                    check("idle_data_zero", 64'(Win_Data_In), 64'd0);
                end
                if (Mem_Rd_En) begin
                    check("rd_addr", 64'(Mem_Addr), 64'(exp_rd_addr));
                    check("rd_while_stall", 64'(Stall_In), 64'd0);
                    exp_rd_addr++;
                    rd_cnt++;
                end
                if (Done) done_cnt++;
                if (!Win_Rst_n) begin
                    clr_low++;
                    lat_armed = 1'b1;
                    lat_cnt   = 0;
                end else if (lat_armed) begin
                    lat_cnt++;
                    if (Win_Valid_In) begin
                        first_lat = lat_cnt;
                        lat_armed = 1'b0;
                    end
                end
                check("window_count", 64'(Window_Count), 64'(exp_win));
            end
        end
    end

    // Stall generator; mode 3 stalls exactly as pixel 4 returns and holds 5 cycles.
    initial begin
        int cyc;
        cyc      = 0;
        Stall_In = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (stall_mode)
                1: Stall_In = (cyc % 3 == 0);
                2: Stall_In = ($urandom_range(0, 3) == 0);
                3: begin
                    Stall_In = 1'b0;
                    if (!hold_done && Mem_Rd_En && (Mem_Addr == AW'(4))) begin
                        @(posedge clk);
                        #1;
                        Stall_In = 1'b1;
                        for (int k = 0; k < 5; k++) begin
                            @(negedge clk);
                            check("hold_no_read", 64'(Mem_Rd_En), 64'd0);
                            check("hold_no_beat", 64'(Win_Valid_In), 64'd0);
                            @(posedge clk);
                            #1;
                        end
                        Stall_In = 1'b0;
                        @(negedge clk);
                        check("hold_release_valid", 64'(Win_Valid_In), 64'd1);
                        check("hold_release_data", 64'(Win_Data_In), 64'(mem[4]));
                        hold_done = 1'b1;
                    end
                end
                default: Stall_In = 1'b0;
            endcase
        end
    end

    task automatic load_frame(input bit rand_data);
        for (int i = 0; i < N; i++) mem[i] = rand_data ? DW'($urandom) : DW'(i + 1);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
        for (int i = 0; i < FL; i++) exp_q.push_back('0);
    endtask

    task automatic run_frame(input int smode, input bit restart, input bit frc, input bit rand_data);
        int n;
        @(posedge clk);
        #1;
        load_frame(rand_data);
        stall_mode = smode;
        force_vo   = frc;
        Start      = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < MAXCYC) begin
            @(posedge clk);
            #1;
            n++;
            Start = restart && (n == 8);
            if (frc && n >= 40) force_vo = 1'b0;
        end
        check("frame_done_in_time", 64'(n < MAXCYC), 64'd1);
        stall_mode = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        force_vo = 1'b0;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("final_window_count", 64'(Window_Count), 64'(N));
        check("busy_after_done", 64'(Busy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("beat_total", 64'(beats_seen), 64'(N + FL));
        check("read_total", 64'(rd_cnt), 64'(N));
        check("clear_cycles", 64'(clr_low), 64'd2);
        if (smode == 0) check("first_beat_latency", 64'(first_lat), 64'd2);
        if (smode == 3) check("skid_hold_seen", 64'(hold_done), 64'd1);
        $display("frame stall=%0d restart=%0d force=%0d: beats=%0d reads=%0d count=%0d cycles=%0d",
                 smode, restart, frc, beats_seen, rd_cnt, Window_Count, n);
    endtask

    task automatic reset_mid_flush();
        int n;
        @(posedge clk);
        #1;
        load_frame(1'b1);
        stall_mode = 0;
        Start      = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        n = 0;
        while (beats_seen < N + 2 && n < MAXCYC) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_flush", 64'(beats_seen >= N + 2), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_valid_in", 64'(Win_Valid_In), 64'd0);
        check("rst_window_count", 64'(Window_Count), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_win_rst_n", 64'(Win_Rst_n), 64'd1);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("no_done_after_abort", 64'(done_cnt), 64'd0);
        check("idle_after_abort", 64'(Busy), 64'd0);
        exp_q.delete();
        $display("abort in flush after %0d beats, count=%0d", beats_seen, Window_Count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        Start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_win_rst_n", 64'(Win_Rst_n), 64'd1);
        check("reset_valid_in", 64'(Win_Valid_In), 64'd0);
        check("reset_data_in", 64'(Win_Data_In), 64'd0);
        check("reset_rd_en", 64'(Mem_Rd_En), 64'd0);
        check("reset_addr", 64'(Mem_Addr), 64'd0);
        check("reset_window_count", 64'(Window_Count), 64'd0);
        $display("reset state checked");
        rst = 1'b0;

        run_frame(0, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0, 1'b0);
        run_frame(3, 1'b0, 1'b0, 1'b1);
        run_frame(2, 1'b1, 1'b0, 1'b1);
        reset_mid_flush();
        run_frame(0, 1'b0, 1'b0, 1'b1);
        run_frame(0, 1'b0, 1'b1, 1'b1);
        run_frame(2, 1'b0, 1'b1, 1'b1);
        for (int f = 0; f < 4; f++) run_frame(2, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
